// File: rtl/q2_panel_ctrl_pkg.sv
// Shared definitions for the Q2 front-panel conditioner: button indices,
// repeat FSM states and the run-flag priority rule.
package q2_panel_ctrl_pkg;

  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_DEP   = 2;
  localparam int BTN_INCP  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_e;

  // Stop and halt outrank start, so a simultaneous start+stop leaves the CPU stopped.
  function automatic logic next_run(input logic run, input logic start,
                                    input logic stop, input logic halt);
    if (stop || halt) return 1'b0;
    if (start)        return 1'b1;
    return run;
  endfunction

endpackage

// File: rtl/q2_panel_ctrl_if.sv
// Panel-side signal bundle: raw active-low pins in, conditioned levels/strobes out.
interface q2_panel_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int NBTN   = 4
);

  logic [DATA_W-1:0] nsw;
  logic [NBTN-1:0]   nbtn;
  logic              halt;
  logic [DATA_W-1:0] sw_val;
  logic [NBTN-1:0]   btn_level;
  logic [NBTN-1:0]   btn_press;
  logic              run;

  modport master (
    output nsw, nbtn, halt,
    input  sw_val, btn_level, btn_press, run
  );

  modport slave (
    input  nsw, nbtn, halt,
    output sw_val, btn_level, btn_press, run
  );

endinterface

// File: rtl/q2_panel_ctrl_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, press edge
// detect and an optional auto-repeat FSM.
module q2_panel_ctrl_debounce
  import q2_panel_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int REPEAT_DLY   = 50000,
  parameter int REPEAT_RATE  = 10000,
  parameter bit REPEAT_EN    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic nbtn_raw,
  output logic level,
  output logic press
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RC_W    = $clog2(RPT_MAX + 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            level_prev_q, level_prev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  rpt_state_e      state_q, state_d;
  logic [RC_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            press_q, press_d;
  logic            fire;
  logic [RC_W-1:0] rpt_cnt_inc;

  // The synchroniser stores the pressed sense so that reset (0) means released.
  always_comb begin
    sync1_d      = ~nbtn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    db_cnt_d     = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign rpt_cnt_inc = (rpt_cnt_q == RC_W'(RPT_MAX)) ? rpt_cnt_q : rpt_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        rpt_cnt_d = '0;
        if (REPEAT_EN && level_q) state_d = DELAY;
      end
      DELAY: begin
        if (!level_q) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RC_W'(REPEAT_DLY - 1)) begin
          fire      = 1'b1;
          state_d   = RPT;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_inc;
        end
      end
      RPT: begin
        if (!level_q) begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RC_W'(REPEAT_RATE - 1)) begin
          fire      = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_inc;
        end
      end
      default: begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
      end
    endcase
    // Gating with the next level keeps a strobe out of the cycle the button reads released.
    press_d = ((level_q & ~level_prev_q) | fire) & level_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      db_cnt_q     <= '0;
      state_q      <= IDLE;
      rpt_cnt_q    <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      rpt_cnt_q    <= rpt_cnt_d;
      press_q      <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/q2_panel_ctrl.sv
// Q2 front-panel conditioner top: data-switch synchroniser, one debounce
// channel per button, and the CPU run flag.
module q2_panel_ctrl
  import q2_panel_ctrl_pkg::*;
#(
  parameter int              DATA_W       = 12,
  parameter int              NBTN         = 4,
  parameter int              DEBOUNCE_CYC = 1000,
  parameter int              REPEAT_DLY   = 50000,
  parameter int              REPEAT_RATE  = 10000,
  parameter logic [NBTN-1:0] REPEAT_MASK  = 4'b1000
) (
  input  logic           clk,
  input  logic           rst,
  q2_panel_ctrl_if.slave bus
);

  logic [DATA_W-1:0] sw_sync1_q, sw_sync1_d;
  logic [DATA_W-1:0] sw_sync2_q, sw_sync2_d;
  logic              run_q, run_d;
  logic [NBTN-1:0]   btn_level_w;
  logic [NBTN-1:0]   btn_press_w;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    q2_panel_ctrl_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .nbtn_raw (bus.nbtn[i]),
      .level    (btn_level_w[i]),
      .press    (btn_press_w[i])
    );
  end

  // Data switches are only synchronised; their consumers sample them on deposit.
  always_comb begin
    sw_sync1_d = ~bus.nsw;
    sw_sync2_d = sw_sync1_q;
    run_d      = next_run(run_q, btn_press_w[BTN_START], btn_press_w[BTN_STOP], bus.halt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      run_q      <= 1'b0;
    end else begin
      sw_sync1_q <= sw_sync1_d;
      sw_sync2_q <= sw_sync2_d;
      run_q      <= run_d;
    end
  end

  assign bus.sw_val    = sw_sync2_q;
  assign bus.btn_level = btn_level_w;
  assign bus.btn_press = btn_press_w;
  assign bus.run       = run_q;

endmodule

// File: tb/tb_q2_panel_ctrl.sv
// Bench for q2_panel_ctrl: cycle model of the panel rules checked every cycle,
// plus directed scenarios with hand-computed timings.
module tb_q2_panel_ctrl;

  localparam int              DATA_W = 12;
  localparam int              NBTN   = 4;
  localparam int              DB     = 4;
  localparam int              DLY    = 8;
  localparam int              RATE   = 3;
  localparam logic [NBTN-1:0] MASK   = 4'b1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  q2_panel_ctrl_if #(.DATA_W(DATA_W), .NBTN(NBTN)) bus ();

  q2_panel_ctrl #(
    .DATA_W       (DATA_W),
    .NBTN         (NBTN),
    .DEBOUNCE_CYC (DB),
    .REPEAT_DLY   (DLY),
    .REPEAT_RATE  (RATE),
    .REPEAT_MASK  (MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NBTN-1:0] nbtn_v, input logic halt_v,
                               input logic [DATA_W-1:0] nsw_v);
    bus.nbtn = nbtn_v;
    bus.halt = halt_v;
    bus.nsw  = nsw_v;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model state: pin history for the 2-cycle sync delay, debounce run length,
  // and k = cycles since the debounced level rose (-1 while released).
  logic [DATA_W-1:0] m_sw_p1 = '0, m_sw_p2 = '0;
  logic [NBTN-1:0]   m_p1 = '0, m_p2 = '0, m_level = '0, m_press = '0;
  int                m_cnt [NBTN] = '{default: 0};
  int                m_k   [NBTN] = '{default: -1};
  logic              m_run = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    logic [NBTN-1:0] n_level, n_press;
    int              n_cnt [NBTN];
    int              n_k   [NBTN];
    int              k;
    if (rst) begin
      m_sw_p1 <= '0;
      m_sw_p2 <= '0;
      m_p1    <= '0;
      m_p2    <= '0;
      m_level <= '0;
      m_press <= '0;
      m_cnt   <= '{default: 0};
      m_k     <= '{default: -1};
      m_run   <= 1'b0;
    end else begin
      n_level = m_level;
      for (int i = 0; i < NBTN; i++) begin
        n_cnt[i] = 0;
        if (m_p2[i] != m_level[i]) begin
          if (m_cnt[i] + 1 == DB) n_level[i] = ~m_level[i];
          else                    n_cnt[i]   = m_cnt[i] + 1;
        end
        k = m_k[i];
        n_k[i] = n_level[i] ? k + 1 : -1;
        n_press[i] = n_level[i] && (k >= 0) &&
                     ((k == 0) || (MASK[i] && ((k == DLY) || ((k > DLY) && ((k - DLY) % RATE == 0)))));
      end
      if (m_press[1] || bus.halt) m_run <= 1'b0;
      else if (m_press[0])        m_run <= 1'b1;
      m_sw_p1 <= ~bus.nsw;
      m_sw_p2 <= m_sw_p1;
      m_p1    <= ~bus.nbtn;
      m_p2    <= m_p1;
      m_level <= n_level;
      m_press <= n_press;
      m_cnt   <= n_cnt;
      m_k     <= n_k;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model sw_val",    32'(bus.sw_val),    32'(m_sw_p2));
      checkOutput("model btn_level", 32'(bus.btn_level), 32'(m_level));
      checkOutput("model btn_press", 32'(bus.btn_press), 32'(m_press));
      checkOutput("model run",       32'(bus.run),       32'(m_run));
    end
  end

  initial begin
    int n_strobe;
    int strobe_at [$];

    rst = 1'b1;
    applyStimulus('1, 1'b0, 12'hFFF);
    waitCycles(3);
    check_en = 1'b1;
    checkOutput("reset sw_val",    32'(bus.sw_val),    32'h0);
    checkOutput("reset btn_level", 32'(bus.btn_level), 32'h0);
    checkOutput("reset btn_press", 32'(bus.btn_press), 32'h0);
    checkOutput("reset run",       32'(bus.run),       32'h0);
    rst = 1'b0;

    $display("[TB] debounce latency on start");
    applyStimulus(4'b1110, 1'b0, 12'h123);
    waitCycles(5);
    checkOutput("t1 level before 6", 32'(bus.btn_level), 32'h0);
    waitCycles(1);
    checkOutput("t1 level at 6", 32'(bus.btn_level), 32'h1);
    checkOutput("t1 no press yet", 32'(bus.btn_press), 32'h0);
    waitCycles(1);
    checkOutput("t1 press", 32'(bus.btn_press), 32'h1);
    checkOutput("t1 run not yet", 32'(bus.run), 32'h0);
    checkOutput("t1 sw_val", 32'(bus.sw_val), 32'hEDC);
    waitCycles(1);
    checkOutput("t1 press single", 32'(bus.btn_press), 32'h0);
    checkOutput("t1 run", 32'(bus.run), 32'h1);

    $display("[TB] glitch reject on stop");
    applyStimulus(4'b1100, 1'b0, 12'h123);
    waitCycles(3);
    applyStimulus(4'b1110, 1'b0, 12'h123);
    waitCycles(10);
    checkOutput("t2 level", 32'(bus.btn_level), 32'h1);
    checkOutput("t2 run", 32'(bus.run), 32'h1);

    $display("[TB] auto-repeat on inc-PC");
    applyStimulus(4'b0110, 1'b0, 12'h0F0);
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(negedge clk);
      if (bus.btn_press[3]) strobe_at.push_back(cyc);
      if (cyc == 30) applyStimulus(4'b1110, 1'b0, 12'h0F0);
    end
    checkOutput("t3 strobe count", 32'(strobe_at.size()), 32'd8);
    if (strobe_at.size() == 8) begin
      checkOutput("t3 first strobe",  32'(strobe_at[0]), 32'd7);
      checkOutput("t3 second strobe", 32'(strobe_at[1]), 32'd15);
      checkOutput("t3 third strobe",  32'(strobe_at[2]), 32'd18);
      checkOutput("t3 last strobe",   32'(strobe_at[7]), 32'd33);
    end

    $display("[TB] halt and stop priority");
    applyStimulus('1, 1'b0, 12'h0F0);
    waitCycles(10);
    checkOutput("t4 run before halt", 32'(bus.run), 32'h1);
    applyStimulus('1, 1'b1, 12'h0F0);
    waitCycles(1);
    checkOutput("t4 halt clears run", 32'(bus.run), 32'h0);
    applyStimulus('1, 1'b0, 12'h0F0);
    waitCycles(2);
    applyStimulus(4'b1100, 1'b0, 12'h0F0);
    waitCycles(7);
    checkOutput("t4 both strobes", 32'(bus.btn_press), 32'h3);
    waitCycles(1);
    checkOutput("t4 stop wins", 32'(bus.run), 32'h0);

    $display("[TB] no repeat on deposit");
    applyStimulus('1, 1'b0, 12'h5A5);
    waitCycles(10);
    applyStimulus(4'b1011, 1'b0, 12'h5A5);
    n_strobe = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (bus.btn_press[2]) n_strobe++;
    end
    checkOutput("t5 deposit strobes", 32'(n_strobe), 32'd1);
    applyStimulus('1, 1'b0, 12'h5A5);
    waitCycles(10);

    $display("[TB] reset mid-repeat");
    applyStimulus(4'b0111, 1'b0, 12'h5A5);
    waitCycles(20);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6 rst sw_val",    32'(bus.sw_val),    32'h0);
    checkOutput("t6 rst btn_level", 32'(bus.btn_level), 32'h0);
    checkOutput("t6 rst btn_press", 32'(bus.btn_press), 32'h0);
    checkOutput("t6 rst run",       32'(bus.run),       32'h0);
    @(negedge clk);
    rst = 1'b0;
    waitCycles(1);
    checkOutput("t6 sw_val at 1", 32'(bus.sw_val), 32'h0);
    waitCycles(1);
    checkOutput("t6 sw_val at 2", 32'(bus.sw_val), 32'hA5A);
    waitCycles(3);
    checkOutput("t6 level at 5", 32'(bus.btn_level), 32'h0);
    waitCycles(1);
    checkOutput("t6 level at 6", 32'(bus.btn_level), 32'h8);
    waitCycles(1);
    checkOutput("t6 press at 7", 32'(bus.btn_press), 32'h8);

    waitCycles(2);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
